rv16c_compress_packer: RTL and testbench

Streaming RV32 instruction compressor and halfword packer for the RV16 toolchain/loader path, the inverse of the compressed-instruction expander. It accepts one 32-bit instruction per handshake and re-encodes it as a 16-bit compressed instruction whenever it maps to a supported RVC form. It then packs the resulting 16/32-bit parcels into an aligned 32-bit word stream for instruction memory. A flush pads a trailing odd halfword with C.NOP.

---
 rtl/rv16c_pkg.sv | 43 ++++
 rtl/rv16c_compress_lut.sv | 89 ++++++++
 rtl/rv16c_compress_packer.sv | 102 ++++++++++
 tb/tb_rv16c_compress_packer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv16c_pkg.sv
// Shared encodings for the RV32 -> RVC compressor and halfword packer.
// Holds the RV32 opcode/funct3 values and the RVC quadrant/funct3 codes.
package rv16c_pkg;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_OP    = 7'b0110011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_ADD  = 3'b000;

  typedef enum logic [1:0] {
    QUAD0 = 2'b00,
    QUAD1 = 2'b01,
    QUAD2 = 2'b10
  } rvc_quad_e;

  localparam logic [2:0] CF3_ADDI     = 3'b000;
  localparam logic [2:0] CF3_LI       = 3'b010;
  localparam logic [2:0] CF3_LUI      = 3'b011;
  localparam logic [2:0] CF3_ADDI16SP = 3'b011;
  localparam logic [2:0] CF3_ADDI4SPN = 3'b000;
  localparam logic [2:0] CF3_SLLI     = 3'b000;
  localparam logic [2:0] CF3_LW       = 3'b010;
  localparam logic [2:0] CF3_LWSP     = 3'b010;
  localparam logic [2:0] CF3_SW       = 3'b110;
  localparam logic [2:0] CF3_CR       = 3'b100;

  localparam logic [15:0] C_NOP = 16'h0001;

  // Compressed register fields can only name x8..x15.
  function automatic logic is_creg(input logic [4:0] r);
    return r[4:3] == 2'b01;
  endfunction

endpackage

// File: rtl/rv16c_compress_lut.sv
// Combinational RV32 -> RVC re-encoder; the if/else chain is the match priority.
// o_is_c is low (and o_cinstr zero) when no supported compressed form exists.
module rv16c_compress_lut
  import rv16c_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [15:0] o_cinstr,
  output logic        o_is_c
);

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  f7;
  logic [11:0] imm_i;
  logic [11:0] imm_s;
  logic        is_addi;
  logic        imm_fits6;
  logic        lui_fits;

  assign opcode = i_instr[6:0];
  assign rd     = i_instr[11:7];
  assign f3     = i_instr[14:12];
  assign rs1    = i_instr[19:15];
  assign rs2    = i_instr[24:20];
  assign f7     = i_instr[31:25];
  assign imm_i  = i_instr[31:20];
  assign imm_s  = {i_instr[31:25], i_instr[11:7]};

  assign is_addi   = (opcode == OP_IMM) && (f3 == F3_ADDI);
  assign imm_fits6 = (&imm_i[11:5]) || (~|imm_i[11:5]);
  // LUI immediate must sign-extend from bit 17 and be nonzero in [17:12].
  assign lui_fits  = ((&i_instr[31:17]) || (~|i_instr[31:17])) && (i_instr[17:12] != 6'd0);

  always_comb begin
    o_cinstr = 16'h0000;
    o_is_c   = 1'b0;
    if (is_addi && (rd == rs1) && imm_fits6) begin
      o_cinstr = {CF3_ADDI, imm_i[5], rd, imm_i[4:0], QUAD1};
      o_is_c   = 1'b1;
    end else if (is_addi && (rd == 5'd2) && (rs1 == 5'd2) && (imm_i[3:0] == 4'd0) &&
                 ((&imm_i[11:9]) || (~|imm_i[11:9])) && (imm_i != 12'd0)) begin
      o_cinstr = {CF3_ADDI16SP, imm_i[9], 5'd2, imm_i[4], imm_i[6], imm_i[8:7], imm_i[5], QUAD1};
      o_is_c   = 1'b1;
    end else if (is_addi && (rs1 == 5'd0) && (rd != 5'd0) && imm_fits6) begin
      o_cinstr = {CF3_LI, imm_i[5], rd, imm_i[4:0], QUAD1};
      o_is_c   = 1'b1;
    end else if (is_addi && (rs1 == 5'd2) && is_creg(rd) && (imm_i[1:0] == 2'd0) &&
                 (imm_i[11:10] == 2'd0) && (imm_i != 12'd0)) begin
      o_cinstr = {CF3_ADDI4SPN, imm_i[5:4], imm_i[9:6], imm_i[2], imm_i[3], rd[2:0], QUAD0};
      o_is_c   = 1'b1;
    end else if ((opcode == OP_IMM) && (f3 == F3_SLLI) && (f7 == 7'd0) && (rd == rs1) &&
                 (rd != 5'd0) && (rs2 != 5'd0)) begin
      o_cinstr = {CF3_SLLI, 1'b0, rd, rs2, QUAD2};
      o_is_c   = 1'b1;
    end else if ((opcode == OP_LUI) && (rd != 5'd0) && (rd != 5'd2) && lui_fits) begin
      o_cinstr = {CF3_LUI, i_instr[17], rd, i_instr[16:12], QUAD1};
      o_is_c   = 1'b1;
    end else if ((opcode == OP_LOAD) && (f3 == F3_LW) && is_creg(rs1) && is_creg(rd) &&
                 (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'd0)) begin
      o_cinstr = {CF3_LW, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], QUAD0};
      o_is_c   = 1'b1;
    end else if ((opcode == OP_LOAD) && (f3 == F3_LW) && (rs1 == 5'd2) && (rd != 5'd0) &&
                 (imm_i[11:8] == 4'd0) && (imm_i[1:0] == 2'd0)) begin
      o_cinstr = {CF3_LWSP, imm_i[5], rd, imm_i[4:2], imm_i[7:6], QUAD2};
      o_is_c   = 1'b1;
    end else if ((opcode == OP_STORE) && (f3 == F3_SW) && is_creg(rs1) && is_creg(rs2) &&
                 (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'd0)) begin
      o_cinstr = {CF3_SW, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], QUAD0};
      o_is_c   = 1'b1;
    end else if ((opcode == OP_JALR) && (f3 == F3_JALR) && (imm_i == 12'd0) && (rs1 != 5'd0) &&
                 ((rd == 5'd0) || (rd == 5'd1))) begin
      // rd=x0 gives C.JR, rd=x1 gives C.JALR; they differ only in bit 12.
      o_cinstr = {CF3_CR, rd[0], rs1, 5'd0, QUAD2};
      o_is_c   = 1'b1;
    end else if ((opcode == OP_OP) && (f3 == F3_ADD) && (f7 == 7'd0) && (rs2 != 5'd0) &&
                 (rd != 5'd0) && (rd == rs1)) begin
      o_cinstr = {CF3_CR, 1'b1, rd, rs2, QUAD2};
      o_is_c   = 1'b1;
    end else if ((opcode == OP_OP) && (f3 == F3_ADD) && (f7 == 7'd0) && (rs2 != 5'd0) &&
                 (rd != 5'd0) && (rs1 == 5'd0)) begin
      o_cinstr = {CF3_CR, 1'b0, rd, rs2, QUAD2};
      o_is_c   = 1'b1;
    end
  end

endmodule

// File: rtl/rv16c_compress_packer.sv
// Streaming compressor: re-encodes each accepted instruction and packs 16/32-bit
// parcels into aligned 32-bit words, padding a trailing halfword with C.NOP on flush.
module rv16c_compress_packer
  import rv16c_pkg::*;
#(
  parameter bit ENABLE = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_instr_valid,
  input  logic [31:0]      i_instr,
  output logic             o_instr_ready,
  input  logic             i_flush,
  output logic             o_word_valid,
  output logic [31:0]      o_word,
  input  logic             i_word_ready,
  output logic             o_flush_done,
  output logic [CNT_W-1:0] o_saved_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [15:0] cinstr;
  logic        lut_is_c;
  logic        use_c;
  logic        slot_free;
  logic        accept;
  logic        pend_v;
  logic [15:0] pend;
  logic        flush_busy;

  rv16c_compress_lut u_lut (
    .i_instr  (i_instr),
    .o_cinstr (cinstr),
    .o_is_c   (lut_is_c)
  );

  assign use_c         = ENABLE && lut_is_c;
  assign slot_free     = !o_word_valid || i_word_ready;
  assign o_instr_ready = slot_free && !flush_busy;
  assign accept        = i_instr_valid && o_instr_ready;

  // Accepts are blocked while flush_busy, so packing and padding never collide.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_word_valid <= 1'b0;
      o_word       <= 32'h0;
      o_flush_done <= 1'b0;
      o_saved_cnt  <= '0;
      pend_v       <= 1'b0;
      pend         <= 16'h0;
      flush_busy   <= 1'b0;
    end else begin
      o_flush_done <= 1'b0;
      if (o_word_valid && i_word_ready) begin
        o_word_valid <= 1'b0;
      end

      if (accept) begin
        if (use_c) begin
          if (pend_v) begin
            o_word       <= {cinstr, pend};
            o_word_valid <= 1'b1;
            pend_v       <= 1'b0;
          end else begin
            pend   <= cinstr;
            pend_v <= 1'b1;
          end
          if (!(&o_saved_cnt)) begin
            o_saved_cnt <= o_saved_cnt + CNT_ONE;
          end
        end else begin
          o_word_valid <= 1'b1;
          // A pending halfword shifts the 32-bit parcel across the word boundary.
          if (pend_v) begin
            o_word <= {i_instr[15:0], pend};
            pend   <= i_instr[31:16];
          end else begin
            o_word <= i_instr;
          end
        end
      end

      if (flush_busy) begin
        if (!pend_v) begin
          flush_busy   <= 1'b0;
          o_flush_done <= 1'b1;
        end else if (slot_free) begin
          o_word       <= {C_NOP, pend};
          o_word_valid <= 1'b1;
          pend_v       <= 1'b0;
          flush_busy   <= 1'b0;
          o_flush_done <= 1'b1;
        end
      end else if (i_flush) begin
        flush_busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv16c_compress_packer.sv
// Scoreboard bench: stimulus pushes hand-computed words, monitors pop on each transfer.
// Extra instances cover ENABLE=0 pass-through and counter saturation with a narrow counter.
module tb_rv16c_compress_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        flush;
  logic        word_valid;
  logic [31:0] word;
  logic        word_ready;
  logic        flush_done;
  logic [15:0] saved_cnt;

  logic        sat_instr_ready;
  logic        sat_word_valid;
  logic [31:0] sat_word;
  logic        sat_flush_done;
  logic [2:0]  sat_cnt;

  logic        nc_valid;
  logic [31:0] nc_instr;
  logic        nc_ready;
  logic        nc_flush;
  logic        nc_word_valid;
  logic [31:0] nc_word;
  logic        nc_word_ready;
  logic        nc_flush_done;
  logic [15:0] nc_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] nc_q[$];
  logic [15:0] hq[$];

  // Directed vectors: instruction, hand-encoded RVC parcel, and whether it compresses.
  logic [31:0] tab_i [0:22] = '{
    32'h00540413, 32'h00000013, 32'hFC010113, 32'hFFF00513, 32'h01010413, 32'h00010413,
    32'h00351513, 32'h00001537, 32'h00001137, 32'hFFFFF537, 32'h00852483, 32'h07C7A403,
    32'h00C12083, 32'h0FC12083, 32'h10012083, 32'h00952223, 32'h00008067, 32'h000280E7,
    32'h00B50533, 32'h00B00533, 32'h02040413, 32'hFE040413, 32'h12345678};
  logic [15:0] tab_h [0:22] = '{
    16'h0415, 16'h0001, 16'h7139, 16'h557D, 16'h0800, 16'h0000,
    16'h050E, 16'h6505, 16'h0000, 16'h757D, 16'h4504, 16'h5FE0,
    16'h40B2, 16'h50FE, 16'h0000, 16'hC144, 16'h8082, 16'h9282,
    16'h952E, 16'h852E, 16'h0000, 16'h1401, 16'h0000};
  bit tab_c [0:22] = '{
    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
    1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
    1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
    1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  logic [31:0] nc_tab [0:3] = '{32'h00540413, 32'h00852483, 32'h007302B3, 32'h00000013};

  always #5 clk = ~clk;

  rv16c_compress_packer #(.ENABLE(1'b1), .CNT_W(16)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr_valid(instr_valid), .i_instr(instr),
    .o_instr_ready(instr_ready), .i_flush(flush), .o_word_valid(word_valid), .o_word(word),
    .i_word_ready(word_ready), .o_flush_done(flush_done), .o_saved_cnt(saved_cnt));

  rv16c_compress_packer #(.ENABLE(1'b1), .CNT_W(3)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr_valid(instr_valid), .i_instr(instr),
    .o_instr_ready(sat_instr_ready), .i_flush(flush), .o_word_valid(sat_word_valid),
    .o_word(sat_word), .i_word_ready(word_ready), .o_flush_done(sat_flush_done),
    .o_saved_cnt(sat_cnt));

  rv16c_compress_packer #(.ENABLE(1'b0), .CNT_W(16)) u_nc (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr_valid(nc_valid), .i_instr(nc_instr),
    .o_instr_ready(nc_ready), .i_flush(nc_flush), .o_word_valid(nc_word_valid),
    .o_word(nc_word), .i_word_ready(nc_word_ready), .o_flush_done(nc_flush_done),
    .o_saved_cnt(nc_cnt));

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", name, act, want);
    end
  endtask

  task automatic report_fail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s", name);
  endtask

  // Main scoreboard: one pop per transfer seen on the output handshake.
  initial begin
    logic [31:0] want;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && word_valid === 1'b1 && word_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_word: got=%h want=none", word);
        end else begin
          want = exp_q.pop_front();
          check_output("word", word, want);
        end
      end
    end
  end

  initial begin
    logic [31:0] want;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && nc_word_valid === 1'b1 && nc_word_ready === 1'b1) begin
        if (nc_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL nc_unexpected_word: got=%h want=none", nc_word);
        end else begin
          want = nc_q.pop_front();
          check_output("nc_word", nc_word, want);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic apply_stimulus(input logic [31:0] ins, input bit with_flush, output int cycles);
    logic rdy;
    cycles = 0;
    rdy = 1'b0;
    instr_valid = 1'b1;
    instr = ins;
    while (!rdy && cycles < 100) begin
      @(negedge clk);
      rdy = instr_ready;
      if (with_flush && rdy) flush = 1'b1;
      @(posedge clk);
      #1;
      cycles++;
    end
    instr_valid = 1'b0;
    flush = 1'b0;
    if (!rdy) report_fail("accept_timeout");
  endtask

  task automatic send(input logic [31:0] ins);
    int cyc;
    apply_stimulus(ins, 1'b0, cyc);
  endtask

  task automatic send_nc(input logic [31:0] ins);
    logic rdy;
    int cycles;
    cycles = 0;
    rdy = 1'b0;
    nc_valid = 1'b1;
    nc_instr = ins;
    while (!rdy && cycles < 100) begin
      @(negedge clk);
      rdy = nc_ready;
      @(posedge clk);
      #1;
      cycles++;
    end
    nc_valid = 1'b0;
    if (!rdy) report_fail("nc_accept_timeout");
  endtask

  task automatic wait_flush_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (flush_done) seen = 1'b1;
    end
    check_output(name, {31'b0, seen}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input string name);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wait_flush_done(name);
  endtask

  task automatic check_counts(input string name);
    check_output(name, {16'b0, saved_cnt}, exp_cnt);
    check_output({name, "_sat"}, {29'b0, sat_cnt}, (exp_cnt > 7) ? 7 : exp_cnt);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = 32'h0;
    flush = 1'b0;
    word_ready = 1'b1;
    nc_valid = 1'b0;
    nc_instr = 32'h0;
    nc_flush = 1'b0;
    nc_word_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_word_valid", {31'b0, word_valid}, 32'd0);
    check_output("rst_word", word, 32'h0);
    check_output("rst_flush_done", {31'b0, flush_done}, 32'd0);
    check_output("rst_saved_cnt", {16'b0, saved_cnt}, 32'd0);
    check_output("rst_instr_ready", {31'b0, instr_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Two C.ADDI parcels pair into one word on the second accept.
    send(32'h00540413);
    exp_q.push_back(32'h04150415);
    send(32'h00540413);
    @(negedge clk);
    check_output("latency_valid", {31'b0, word_valid}, 32'd1);
    @(posedge clk);
    #1;
    exp_cnt = 2;
    check_counts("cnt_addi");

    // Lone C.LW is padded with C.NOP on flush.
    send(32'h00852483);
    exp_q.push_back(32'h00014504);
    do_flush("flush_done_lw");
    exp_cnt = 3;
    check_counts("cnt_lw");

    // 32-bit ADD straddles a pending halfword; flush in the same cycle pads the tail.
    send(32'h00540413);
    exp_q.push_back(32'h02B30415);
    exp_q.push_back(32'h00010073);
    apply_stimulus(32'h007302B3, 1'b1, cyc);
    wait_flush_done("flush_done_add");
    exp_cnt = 4;
    check_counts("cnt_add");

    // Downstream stall holds the word and back-pressures the input.
    word_ready = 1'b0;
    exp_q.push_back(32'h007302B3);
    send(32'h007302B3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("stall_ready", {31'b0, instr_ready}, 32'd0);
      check_output("stall_valid", {31'b0, word_valid}, 32'd1);
      check_output("stall_word", word, 32'h007302B3);
    end
    @(posedge clk);
    #1;
    word_ready = 1'b1;

    // Directed table streamed back to back; expected words come from the halfword stream.
    for (int i = 0; i < 23; i++) begin
      if (tab_c[i]) begin
        hq.push_back(tab_h[i]);
        exp_cnt++;
      end else begin
        hq.push_back(tab_i[i][15:0]);
        hq.push_back(tab_i[i][31:16]);
      end
      while (hq.size() >= 2) begin
        exp_q.push_back({hq[1], hq[0]});
        void'(hq.pop_front());
        void'(hq.pop_front());
      end
      apply_stimulus(tab_i[i], 1'b0, cyc);
      check_output("throughput", cyc, 32'd1);
    end
    if (hq.size() == 1) begin
      exp_q.push_back({16'h0001, hq[0]});
      void'(hq.pop_front());
    end
    do_flush("flush_done_table");
    check_counts("cnt_table");

    // Reset with a stalled word, a pending halfword and a flush in progress.
    word_ready = 1'b0;
    send(32'h00540413);
    send(32'h007302B3);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check_output("busy_ready", {31'b0, instr_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_output("mid_rst_word_valid", {31'b0, word_valid}, 32'd0);
    check_output("mid_rst_word", word, 32'h0);
    check_output("mid_rst_flush_done", {31'b0, flush_done}, 32'd0);
    check_output("mid_rst_instr_ready", {31'b0, instr_ready}, 32'd1);
    exp_cnt = 0;
    check_counts("mid_rst_cnt");
    @(posedge clk);
    #1;
    word_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("post_rst_no_done", {31'b0, flush_done}, 32'd0);
      check_output("post_rst_no_word", {31'b0, word_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // ENABLE=0 instance must pass every instruction through untouched.
    for (int i = 0; i < 4; i++) begin
      nc_q.push_back(nc_tab[i]);
      send_nc(nc_tab[i]);
    end
    @(negedge clk);
    check_output("nc_saved_cnt", {16'b0, nc_cnt}, 32'd0);

    for (int i = 0; i < 50 && (exp_q.size() != 0 || nc_q.size() != 0); i++) @(negedge clk);
    check_output("queues_drained", exp_q.size() + nc_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
